// File: rtl/truco_series_scoreboard.sv
// N-team Truco series scoreboard: per-hand scoring up to TARGET, game counting,
// runtime best-of series detection and saturating per-team series-win records.
module truco_series_scoreboard #(
  parameter int unsigned N_TEAMS = 2,
  parameter int unsigned PTS_W   = 4,
  parameter int unsigned TARGET  = 12,
  parameter int unsigned REC_W   = 3,
  localparam int unsigned TEAM_W = (N_TEAMS > 2) ? $clog2(N_TEAMS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_clr,
  input  logic                       i_clr_rec,
  input  logic                       i_win,
  input  logic [TEAM_W-1:0]          i_win_team,
  input  logic [3:0]                 i_pts,
  input  logic [1:0]                 i_best_of,
  input  logic                       i_new_series,
  output logic [N_TEAMS*PTS_W-1:0]   o_score,
  output logic [N_TEAMS*3-1:0]       o_games,
  output logic [N_TEAMS*REC_W-1:0]   o_rec,
  output logic                       o_game_end,
  output logic                       o_series_end,
  output logic [TEAM_W-1:0]          o_winner
);

  // Sum is wide enough for a full score plus the largest hand value.
  localparam int unsigned SUM_W = (PTS_W >= 4) ? PTS_W + 1 : 5;
  localparam logic [SUM_W-1:0]  TargetS = SUM_W'(TARGET);
  localparam logic [TEAM_W:0]   NTeamsW = (TEAM_W + 1)'(N_TEAMS);

  typedef enum logic [1:0] {StPlay, StGameOver, StSeriesOver} state_e;

  state_e                                r_state, w_state_d;
  logic [N_TEAMS-1:0][PTS_W-1:0]         r_score, w_score_d;
  logic [N_TEAMS-1:0][2:0]               r_games, w_games_d;
  logic [N_TEAMS-1:0][REC_W-1:0]         r_rec, w_rec_d;
  logic [TEAM_W-1:0]                     r_winner, w_winner_d;
  logic [1:0]                            r_mode, w_mode_d;

  logic             w_accept;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_sat;
  logic [2:0]       w_games_inc;
  logic [2:0]       w_required;
  logic [REC_W-1:0] w_rec_inc;

  always_comb begin
    w_state_d  = r_state;
    w_score_d  = r_score;
    w_games_d  = r_games;
    w_rec_d    = r_rec;
    w_winner_d = r_winner;
    w_mode_d   = r_mode;

    w_accept    = i_win && ({1'b0, i_win_team} < NTeamsW) && (i_pts != 4'd0);
    w_sum       = SUM_W'(r_score[i_win_team]) + SUM_W'(i_pts);
    w_sat       = (w_sum > TargetS) ? TargetS : w_sum;
    w_games_inc = (r_games[r_winner] == 3'd7) ? 3'd7 : r_games[r_winner] + 3'd1;
    w_required  = {1'b0, r_mode} + 3'd1;
    w_rec_inc   = (r_rec[r_winner] == '1) ? r_rec[r_winner] : r_rec[r_winner] + REC_W'(1);

    unique case (r_state)
      StPlay: begin
        if (w_accept) begin
          w_score_d[i_win_team] = w_sat[PTS_W-1:0];
          if (w_sat == TargetS) begin
            w_state_d  = StGameOver;
            w_winner_d = i_win_team;
          end
        end
      end
      StGameOver: begin
        w_score_d          = '0;
        w_games_d[r_winner] = w_games_inc;
        if (w_games_inc == w_required) begin
          w_rec_d[r_winner] = w_rec_inc;
          w_state_d         = StSeriesOver;
        end else begin
          w_state_d = StPlay;
        end
      end
      StSeriesOver: begin
        if (i_new_series) begin
          w_games_d = '0;
          w_mode_d  = i_best_of;
          w_state_d = StPlay;
        end
      end
      default: w_state_d = StPlay;
    endcase

    // Record clear overrides any increment made this cycle.
    if (i_clr_rec) begin
      w_rec_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= StPlay;
      r_score  <= '0;
      r_games  <= '0;
      r_rec    <= '0;
      r_winner <= '0;
      r_mode   <= i_best_of;
    end else begin
      r_state  <= w_state_d;
      r_score  <= w_score_d;
      r_games  <= w_games_d;
      r_rec    <= w_rec_d;
      r_winner <= w_winner_d;
      r_mode   <= w_mode_d;
    end
  end

  assign o_score      = r_score;
  assign o_games      = r_games;
  assign o_rec        = r_rec;
  assign o_winner     = r_winner;
  assign o_game_end   = (r_state == StGameOver);
  assign o_series_end = (r_state == StSeriesOver);

endmodule

// File: tb/tb_truco_series_scoreboard.sv
// Directed bench for truco_series_scoreboard (3 teams): a per-edge scoring model
// checked every cycle, plus hand-computed literal checks along the sequence.
module tb_truco_series_scoreboard;

  localparam int unsigned NT  = 3;
  localparam int unsigned PW  = 4;
  localparam int unsigned TGT = 12;
  localparam int unsigned RW  = 3;
  localparam int unsigned TW  = 2;

  logic              clk = 1'b0;
  logic              clr, clr_rec, win, new_series;
  logic [TW-1:0]     win_team;
  logic [3:0]        pts;
  logic [1:0]        best_of;
  logic [NT*PW-1:0]  score;
  logic [NT*3-1:0]   games;
  logic [NT*RW-1:0]  rec;
  logic              game_end, series_end;
  logic [TW-1:0]     winner;

  always #5 clk = ~clk;

  truco_series_scoreboard #(
    .N_TEAMS(NT), .PTS_W(PW), .TARGET(TGT), .REC_W(RW)
  ) dut (
    .i_clk(clk), .i_clr(clr), .i_clr_rec(clr_rec), .i_win(win),
    .i_win_team(win_team), .i_pts(pts), .i_best_of(best_of),
    .i_new_series(new_series), .o_score(score), .o_games(games), .o_rec(rec),
    .o_game_end(game_end), .o_series_end(series_end), .o_winner(winner)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: phase 0 = hands being played, 1 = game just won, 2 = series decided.
  int m_score [NT];
  int m_games [NT];
  int m_rec   [NT];
  int m_winner, m_required, m_phase;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NT; i++) begin
        m_score[i] = 0; m_games[i] = 0; m_rec[i] = 0;
      end
      m_winner = 0; m_phase = 0; m_required = int'(best_of) + 1;
    end else begin
      if (m_phase == 0) begin
        if (win && int'(win_team) < NT && pts != 0) begin
          int t;
          t = int'(win_team);
          m_score[t] = m_score[t] + int'(pts);
          if (m_score[t] > TGT) m_score[t] = TGT;
          if (m_score[t] == TGT) begin m_phase = 1; m_winner = t; end
        end
      end else if (m_phase == 1) begin
        for (int i = 0; i < NT; i++) m_score[i] = 0;
        if (m_games[m_winner] < 7) m_games[m_winner]++;
        if (m_games[m_winner] == m_required) begin
          if (m_rec[m_winner] < (1 << RW) - 1) m_rec[m_winner]++;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end else if (new_series) begin
        for (int i = 0; i < NT; i++) m_games[i] = 0;
        m_required = int'(best_of) + 1;
        m_phase = 0;
      end
      if (clr_rec) for (int i = 0; i < NT; i++) m_rec[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NT; i++) begin
        check($sformatf("score%0d", i), int'(score[i*PW +: PW]), m_score[i]);
        check($sformatf("games%0d", i), int'(games[i*3 +: 3]), m_games[i]);
        check($sformatf("rec%0d", i), int'(rec[i*RW +: RW]), m_rec[i]);
      end
      check("game_end", int'(game_end), int'(m_phase == 1));
      check("series_end", int'(series_end), int'(m_phase == 2));
      check("winner", int'(winner), m_winner);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    clr = 1'b0; clr_rec = 1'b0; win = 1'b0; new_series = 1'b0;
    win_team = '0; pts = 4'd0;
  endtask

  task automatic hand(input int team, input int p);
    win = 1'b1; win_team = TW'(team); pts = 4'(p);
    tick();
  endtask

  initial begin
    clr = 1'b1; clr_rec = 1'b0; win = 1'b0; new_series = 1'b0;
    win_team = '0; pts = 4'd0; best_of = 2'b01;
    tick();
    cmp_en = 1'b1;
    check("rst_score", int'(score), 0);
    check("rst_games", int'(games), 0);
    check("rst_rec", int'(rec), 0);
    check("rst_series_end", int'(series_end), 0);

    // Back-to-back hands for team 0 reach the target on the fourth.
    hand(0, 3); check("s0_3", int'(score[3:0]), 3);
    hand(0, 3); check("s0_6", int'(score[3:0]), 6);
    hand(0, 3); check("s0_9", int'(score[3:0]), 9);
    hand(0, 3); check("s0_12", int'(score[3:0]), 12);
    check("game_end_pulse", int'(game_end), 1);
    tick();
    check("cleared_score", int'(score), 0);
    check("games0_1", int'(games[2:0]), 1);
    check("bo3_no_series", int'(series_end), 0);

    // Illegal hands are ignored.
    hand(1, 0); check("pts0_ignored", int'(score), 0);
    hand(3, 6); check("team3_ignored", int'(score), 0);

    // Best-of-1 with saturation past the target.
    best_of = 2'b00; clr = 1'b1; tick();
    hand(1, 9); check("s1_9", int'(score[7:4]), 9);
    hand(1, 6); check("s1_sat12", int'(score[7:4]), 12);
    check("winner1", int'(winner), 1);
    hand(0, 3);
    check("gameover_win_ignored", int'(score), 0);
    check("series_end_b", int'(series_end), 1);
    check("rec1_1", int'(rec[5:3]), 1);
    hand(0, 3);
    check("series_win_ignored", int'(score), 0);
    best_of = 2'b01; new_series = 1'b1; win = 1'b1; win_team = 2'd0; pts = 4'd3; tick();
    check("ns_drops_win", int'(score), 0);
    check("ns_games", int'(games), 0);
    check("ns_play", int'(series_end), 0);

    // Best-of-3 across three teams; mid-series mode change must not matter.
    hand(2, 12); tick();
    best_of = 2'b00;
    hand(0, 12); tick();
    check("midseries_bestof_ignored", int'(series_end), 0);
    hand(1, 6); hand(0, 3); hand(2, 9); hand(2, 3);
    check("score_pack", int'(score), 12'hC63);
    tick();
    check("games_pack", int'(games), 9'b010_000_001);
    check("winner2", int'(winner), 2);
    check("series_end_c", int'(series_end), 1);
    new_series = 1'b1; tick();
    check("ns_games_c", int'(games), 0);

    // Clr mid-game wipes everything including records.
    hand(0, 9); check("s0_9_mid", int'(score[3:0]), 9);
    clr = 1'b1; tick();
    check("clr_score", int'(score), 0);
    check("clr_rec", int'(rec), 0);
    check("clr_winner", int'(winner), 0);

    // ClrRec coinciding with a series win leaves the record at zero.
    hand(0, 12); clr_rec = 1'b1; tick();
    check("clrrec_series", int'(series_end), 1);
    check("clrrec_wins", int'(rec), 0);
    new_series = 1'b1; tick();

    // Record saturation at 7.
    for (int k = 1; k <= 8; k++) begin
      hand(0, 12); tick();
      check($sformatf("rec0_sat_%0d", k), int'(rec[2:0]), (k < 7) ? k : 7);
      new_series = 1'b1; tick();
    end
    clr_rec = 1'b1; tick();
    check("clrrec_idle", int'(rec), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
